axi4_master_bridge: RTL
=======================

Name: axi4_master_bridge

Overview:
Single-outstanding AXI4 initiator. It converts the core's simple request/response port (IFU/LSU arbiter side) into AXI4 master-channel traffic toward the SoC or the simulation memory model. Reads are INCR bursts of 1..256 beats. Writes are single-beat. It sits between the core's memory arbiter and the top-level io_master_* pins.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (fixed 32; arsize/awsize = 3'b010)
ID, 4'h0, constant value driven on arid/awid
TIMEOUT_CYCLES, 1024, watchdog limit (optional feature only)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low (0 = reset)
req_valid  in  1  request valid
req_ready  out  1  bridge accepts request
req_wen  in  1  1 = write, 0 = read
req_addr  in  32  byte address, word aligned
req_len  in  8  read beats minus 1 (ignored on write)
req_wdata  in  32  write data
req_wstrb  in  4  write byte strobes
resp_valid  out  1  response beat valid
resp_ready  in  1  consumer accepts beat
resp_rdata  out  32  read data (0 on write response)
resp_last  out  1  final beat of transaction
resp_err  out  1  rresp/bresp != OKAY (or timeout)
awvalid/awready/awaddr[32]/awid[4]/awlen[8]/awsize[3]/awburst[2]  out/in/out...  AXI AW channel
wvalid/wready/wdata[32]/wstrb[4]/wlast  out/in/out  AXI W channel
bvalid/bready/bresp[2]/bid[4]  in/out/in/in  AXI B channel
arvalid/arready/araddr[32]/arid[4]/arlen[8]/arsize[3]/arburst[2]  out/in/out...  AXI AR channel
rvalid/rready/rdata[32]/rresp[2]/rlast/rid[4]  in/out/in/in/in/in  AXI R channel

Behaviour:
- States: IDLE, AR, R, AW_W, B.
- Reset (reset==0 at a clock edge): state=IDLE; all valid/ready outputs 0; aw_done=w_done=0; beat counter=0. Reset mid-transaction abandons it immediately with no response.
- IDLE: req_ready=1. On req_valid, latch addr/len/wdata/wstrb/wen. wen=0 goes to AR; wen=1 goes to AW_W. Nothing is issued on the IDLE cycle itself.
- AR: arvalid=1, araddr/arlen from latch, arburst=2'b01, arsize=3'b010. Held stable until arready. On arready, go to R and clear the beat counter.
- R: rready = resp_ready; resp_valid = rvalid; resp_rdata = rdata; resp_last = rlast; resp_err = (rresp!=0). These are combinational pass-throughs, so there is zero added latency. Each rvalid&&rready handshake increments the counter.
  - On a handshake with rlast, go to IDLE.
  - rlast arriving with counter != latched len sets resp_err on that beat.
  - Beats after len+1 without rlast also set resp_err on each beat; the bridge keeps consuming until rlast.
- AW_W: awvalid=!aw_done and wvalid=!w_done, both asserted in the same cycle. wlast=1, awlen=0, awburst=2'b01.
  - aw_done sets on awready; w_done sets on wready. Either order is allowed, including the same cycle.
  - When both are done, go to B and clear the flags.
- B: bready = resp_ready; resp_valid = bvalid; resp_last=1; resp_rdata=0; resp_err = (bresp!=0). On handshake, go to IDLE.
- req_ready=0 in every state except IDLE. The earliest next request is accepted on the cycle after the final response handshake.
- Once asserted, arvalid/awvalid/wvalid and their payloads never drop or change before the handshake.
- rid/bid are ignored (single outstanding, ID constant).

Optional Feature:
AXI_MASTER_TIMEOUT_EN:
- Defined: a 16-bit counter clears on entry to AR/AW_W and on every AXI handshake, and increments otherwise while not in IDLE.
- On reaching TIMEOUT_CYCLES, the bridge drops all valids and presents resp_valid=1, resp_err=1, resp_last=1, resp_rdata=0 until resp_ready. It then returns to IDLE.
- Undefined: no counter; the bridge waits indefinitely.

Test Plan:
- Single read: req addr 0x3000_0000, len 0; slave returns 0xDEADBEEF with rlast, rresp 0 -> arlen=0; one resp beat with rdata 0xDEADBEEF, last=1, err=0; req_ready high the next cycle.
- Burst read len 3 with rvalid gapped and resp_ready toggling -> 4 beats delivered in order; last only on the 4th; no beat lost or duplicated.
- Write 0xA5A5A5A5 strb 4'b0011 to 0x8000_0004, slave asserts wready 2 cycles before awready -> awvalid/wvalid each drop exactly after their own handshake; a single B handshake gives resp_valid with err=0.
- Write with bresp=2'b10 -> resp_err=1, resp_last=1.
- reset=0 asserted while in R after 2 of 4 beats -> next cycle: IDLE, all valids/readies 0, req_ready=1 after reset released.
- AXI_MASTER_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, arready held 0 -> arvalid drops after 16 cycles; resp_err=1, resp_last=1.

Source files
------------

// File: rtl/axi4_master_bridge_if.sv
// ---------------------------------------------------------------------------
// axi4_master_bridge_if
//   Bundles the core-side request/response port and the five AXI4 master
//   channels used by axi4_master_bridge.
//
//   Core side : req_valid/req_ready/req_wen/req_addr/req_len/req_wdata/
//               req_wstrb (request), resp_valid/resp_ready/resp_rdata/
//               resp_last/resp_err (response beats)
//   AXI side  : AW, W, B, AR, R channels (single ID, 32-bit data)
//
//   modport master : the bridge (drives requests onto AXI, answers the core)
//   modport slave  : the environment (core + AXI subordinate/memory model)
// ---------------------------------------------------------------------------
interface axi4_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // core request / response
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wen;
    logic [ADDR_W-1:0]     req_addr;
    logic [7:0]            req_len;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_wstrb;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_last;
    logic                  resp_err;

    // AW channel
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic [3:0]            awid;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;

    // W channel
    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;

    // B channel
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic [3:0]            bid;

    // AR channel
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;
    logic [3:0]            arid;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;

    // R channel
    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic [3:0]            rid;

    modport master (
        input  req_valid, req_wen, req_addr, req_len, req_wdata, req_wstrb,
        input  resp_ready,
        input  awready, wready, bvalid, bresp, bid,
        input  arready, rvalid, rdata, rresp, rlast, rid,
        output req_ready, resp_valid, resp_rdata, resp_last, resp_err,
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast, bready,
        output arvalid, araddr, arid, arlen, arsize, arburst, rready
    );

    modport slave (
        output req_valid, req_wen, req_addr, req_len, req_wdata, req_wstrb,
        output resp_ready,
        output awready, wready, bvalid, bresp, bid,
        output arready, rvalid, rdata, rresp, rlast, rid,
        input  req_ready, resp_valid, resp_rdata, resp_last, resp_err,
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast, bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready
    );
endinterface

// File: rtl/axi4_master_bridge.sv
// ---------------------------------------------------------------------------
// axi4_master_bridge
//   Single-outstanding AXI4 initiator. Converts the core's request/response
//   port into AXI4 traffic: reads are INCR bursts of req_len+1 beats, writes
//   are single beats. R and B responses are passed combinationally to the
//   core response port (no added latency).
//
//   Ports:
//     clock  : system clock, rising edge
//     reset  : synchronous, active-low (0 = reset)
//     bus    : axi4_master_bridge_if.master (core req/resp + AW/W/B/AR/R)
//
//   Optional feature (macro AXI_MASTER_TIMEOUT_EN):
//     A 16-bit watchdog counts cycles without any AXI handshake while a
//     transaction is in flight. After TIMEOUT_CYCLES such cycles the bridge
//     drops all valids and returns one error response (err=1, last=1,
//     rdata=0) to the core. Without the macro the bridge waits forever.
// ---------------------------------------------------------------------------
module axi4_master_bridge #(
    parameter int         ADDR_W         = 32,
    parameter int         DATA_W         = 32,
    parameter logic [3:0] ID             = 4'h0,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    axi4_master_bridge_if.master bus
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_AR   = 3'd1;
    localparam logic [2:0] ST_R    = 3'd2;
    localparam logic [2:0] ST_AW_W = 3'd3;
    localparam logic [2:0] ST_B    = 3'd4;
    localparam logic [2:0] ST_TO   = 3'd5;

    logic [2:0]            state;
    logic                  aw_done;
    logic                  w_done;
    logic [8:0]            beat_cnt;

    logic [ADDR_W-1:0]     addr_q;
    logic [7:0]            len_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wstrb_q;

    logic                  ar_hs;
    logic                  r_hs;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  b_hs;
    logic                  aw_next;
    logic                  w_next;
    logic                  beat_err;

    // Nine bits so a slave that overruns a 256-beat burst is still flagged;
    // the counter sticks at all-ones instead of wrapping back into range.
    function automatic logic [8:0] sat_inc(input logic [8:0] v);
        return (v == 9'h1FF) ? v : v + 9'd1;
    endfunction

    assign ar_hs   = (state == ST_AR)   && bus.arready;
    assign r_hs    = (state == ST_R)    && bus.rvalid && bus.resp_ready;
    assign aw_hs   = (state == ST_AW_W) && !aw_done && bus.awready;
    assign w_hs    = (state == ST_AW_W) && !w_done  && bus.wready;
    assign b_hs    = (state == ST_B)    && bus.bvalid && bus.resp_ready;
    assign aw_next = aw_done || aw_hs;
    assign w_next  = w_done  || w_hs;

    // Early rlast (count short of len) or any beat past len+1 is an error.
    assign beat_err = bus.rlast ? (beat_cnt != {1'b0, len_q})
                                : (beat_cnt >  {1'b0, len_q});

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] to_cnt;
    logic        any_hs;
    logic        timeout_hit;

    assign any_hs      = ar_hs || r_hs || aw_hs || w_hs || b_hs;
    assign timeout_hit = (state != ST_IDLE) && (state != ST_TO) &&
                         !any_hs && (to_cnt == TO_LAST);

    // Held at zero in IDLE, so it starts from zero on entry to AR / AW_W.
    always_ff @(posedge clock) begin
        if (!reset) begin
            to_cnt <= 16'd0;
        end else if ((state == ST_IDLE) || any_hs) begin
            to_cnt <= 16'd0;
        end else if (to_cnt != 16'hFFFF) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end
`else
    logic timeout_hit;
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= ST_IDLE;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            beat_cnt <= 9'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        state <= bus.req_wen ? ST_AW_W : ST_AR;
                    end
                end
                ST_AR: begin
                    if (bus.arready) begin
                        state    <= ST_R;
                        beat_cnt <= 9'd0;
                    end
                end
                ST_R: begin
                    if (r_hs) begin
                        beat_cnt <= sat_inc(beat_cnt);
                        if (bus.rlast) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_AW_W: begin
                    if (aw_next && w_next) begin
                        state   <= ST_B;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end else begin
                        aw_done <= aw_next;
                        w_done  <= w_next;
                    end
                end
                ST_B: begin
                    if (b_hs) begin
                        state <= ST_IDLE;
                    end
                end
                ST_TO: begin
                    if (bus.resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A stalled write may abandon with one flag already set; clear
            // both so the next write starts with both channels pending.
            if (timeout_hit) begin
                state   <= ST_TO;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
        end
    end

    // Request payload; only captured while idle, so it stays stable while
    // the AR/AW/W valids are up.
    always_ff @(posedge clock) begin
        if ((state == ST_IDLE) && bus.req_valid) begin
            addr_q  <= bus.req_addr;
            len_q   <= bus.req_len;
            wdata_q <= bus.req_wdata;
            wstrb_q <= bus.req_wstrb;
        end
    end

    always_comb begin
        // req_ready is held low while reset is asserted.
        bus.req_ready  = reset && (state == ST_IDLE);

        bus.arvalid    = (state == ST_AR);
        bus.araddr     = addr_q;
        bus.arid       = ID;
        bus.arlen      = len_q;
        bus.arsize     = 3'b010;
        bus.arburst    = 2'b01;
        bus.rready     = (state == ST_R) && bus.resp_ready;

        bus.awvalid    = (state == ST_AW_W) && !aw_done;
        bus.awaddr     = addr_q;
        bus.awid       = ID;
        bus.awlen      = 8'd0;
        bus.awsize     = 3'b010;
        bus.awburst    = 2'b01;
        bus.wvalid     = (state == ST_AW_W) && !w_done;
        bus.wdata      = wdata_q;
        bus.wstrb      = wstrb_q;
        bus.wlast      = 1'b1;
        bus.bready     = (state == ST_B) && bus.resp_ready;

        bus.resp_valid = 1'b0;
        bus.resp_rdata = '0;
        bus.resp_last  = 1'b0;
        bus.resp_err   = 1'b0;
        case (state)
            ST_R: begin
                bus.resp_valid = bus.rvalid;
                bus.resp_rdata = bus.rdata;
                bus.resp_last  = bus.rlast;
                bus.resp_err   = (bus.rresp != 2'b00) || beat_err;
            end
            ST_B: begin
                bus.resp_valid = bus.bvalid;
                bus.resp_last  = 1'b1;
                bus.resp_err   = (bus.bresp != 2'b00);
            end
            ST_TO: begin
                bus.resp_valid = 1'b1;
                bus.resp_last  = 1'b1;
                bus.resp_err   = 1'b1;
            end
            default: ;
        endcase
    end

    // rid/bid carry no information with a single constant ID in flight.
    logic unused_bits;
    assign unused_bits = ^{bus.rid, bus.bid, 32'(TIMEOUT_CYCLES)};

endmodule
